input_debouncer: RTL and testbench

- Front-end conditioning stage for the board pushbuttons and slide switches.
- Synchronises each raw pad input into the clk_i domain and debounces it with a per-bit stability counter.
- Outputs drive push_i / switch_i of the buttons peripheral directly.
- The buttons edge and level detection therefore only ever sees clean, glitch-free, single-transition signals.

---
 rtl/input_debouncer_if.sv | 54 +++++
 rtl/input_debouncer.sv | 146 ++++++++++++++
 tb/tb_input_debouncer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : input_debouncer_if                                              |
// | Purpose  : Bundles the raw pad inputs and the conditioned outputs of the   |
// |            pushbutton / slide-switch debouncer.                            |
// | Signals  : raw_push_i   [N_PUSH]    raw pushbutton pads (active high)      |
// |            raw_switch_i [N_SWITCH]  raw slide-switch pads                  |
// |            push_o       [N_PUSH]    debounced pushbuttons                  |
// |            switch_o     [N_SWITCH]  debounced switches                     |
// |            busy_o                   any lane currently counting            |
// |            rise_o/fall_o [W]        edge pulses, only when the macro       |
// |                                     INPUT_DEBOUNCER_EDGE_EN is defined     |
// | Modports : master (pad side / observer), slave (debouncer)                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface input_debouncer_if #(
  parameter int N_PUSH   = 10,
  parameter int N_SWITCH = 8
);
  localparam int c_width = N_PUSH + N_SWITCH;

  logic [N_PUSH-1:0]   raw_push_i;
  logic [N_SWITCH-1:0] raw_switch_i;
  logic [N_PUSH-1:0]   push_o;
  logic [N_SWITCH-1:0] switch_o;
  logic                busy_o;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic [c_width-1:0]  rise_o;
  logic [c_width-1:0]  fall_o;

  modport master (
    output raw_push_i, raw_switch_i,
    input  push_o, switch_o, busy_o, rise_o, fall_o
  );

  modport slave (
    input  raw_push_i, raw_switch_i,
    output push_o, switch_o, busy_o, rise_o, fall_o
  );
`else
  modport master (
    output raw_push_i, raw_switch_i,
    input  push_o, switch_o, busy_o
  );

  modport slave (
    input  raw_push_i, raw_switch_i,
    output push_o, switch_o, busy_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : input_debouncer                                                 |
// | Purpose  : Synchronises and debounces the board pushbuttons and slide      |
// |            switches. Each bit is an independent lane: 2-flop synchroniser, |
// |            a stability counter and an output flop. The output follows the  |
// |            synchronised input only after it has differed for STABLE_CYCLES |
// |            consecutive cycles.                                             |
// | Ports    : clk_i   system clock                                            |
// |            rst_ni  asynchronous active-low reset                           |
// |            bus     input_debouncer_if.slave (raw pads in, clean levels,    |
// |                    busy and optional edge pulses out)                      |
// | Options  : INPUT_DEBOUNCER_EDGE_EN - adds registered rise_o/fall_o pulses  |
// |            one cycle after each lane's output changes.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module input_debouncer #(
  parameter int N_PUSH        = 10,
  parameter int N_SWITCH      = 8,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input_debouncer_if.slave  bus
);

  localparam int               c_width    = N_PUSH + N_SWITCH;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

  // The counter must be able to hold STABLE_CYCLES-1. For CNT_W >= 31 every
  // positive int already fits, so only narrower counters need the range test.
  generate
    if (STABLE_CYCLES < 1 ||
        (CNT_W < 31 && STABLE_CYCLES > ((1 << CNT_W) - 1))) begin : g_bad_stable_cycles
      $error("input_debouncer: STABLE_CYCLES out of range 1 .. 2**CNT_W-1");
    end
  endgenerate

  // Push lanes occupy the low bits, switch lanes sit above them.
  logic [c_width-1:0] w_raw;
  logic [c_width-1:0] w_out;
  logic [c_width-1:0] w_cnt_nz;

  logic [c_width-1:0] s1_q, s1_d;
  logic [c_width-1:0] s2_q, s2_d;

  assign w_raw = {bus.raw_switch_i, bus.raw_push_i};

  always_comb begin
    s1_d = w_raw;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic [c_width-1:0] w_rise;
  logic [c_width-1:0] w_fall;
`endif

  generate
    for (genvar i = 0; i < c_width; i++) begin : g_lane
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             out_q, out_d;

      // Any sample equal to the current output clears the count, so a bounce
      // restarts the whole stability window. The terminal compare also keeps
      // the counter from ever wrapping.
      always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (s2_q[i] == out_q) begin
          cnt_d = '0;
        end else if (cnt_q == c_cnt_last) begin
          out_d = s2_q[i];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          out_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign w_out[i]    = out_q;
      assign w_cnt_nz[i] = |cnt_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
      // out_dly_q lags out_q by one cycle; the pulses are registered from the
      // comparison, so they appear one cycle after the output moved.
      logic out_dly_q, out_dly_d;
      logic rise_q, rise_d;
      logic fall_q, fall_d;

      always_comb begin
        out_dly_d = out_q;
        rise_d    = out_q & ~out_dly_q;
        fall_d    = ~out_q & out_dly_q;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_dly_q <= 1'b0;
          rise_q    <= 1'b0;
          fall_q    <= 1'b0;
        end else begin
          out_dly_q <= out_dly_d;
          rise_q    <= rise_d;
          fall_q    <= fall_d;
        end
      end

      assign w_rise[i] = rise_q;
      assign w_fall[i] = fall_q;
`endif
    end
  endgenerate

  assign bus.push_o   = w_out[N_PUSH-1:0];
  assign bus.switch_o = w_out[c_width-1:N_PUSH];
  // Derived straight from the counter flops, so it carries no extra delay.
  assign bus.busy_o   = |w_cnt_nz;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  assign bus.rise_o = w_rise;
  assign bus.fall_o = w_fall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_input_debouncer                                              |
// | Purpose  : Self-checking bench for input_debouncer. dut_a uses             |
// |            STABLE_CYCLES=4, dut_b uses STABLE_CYCLES=1 (minimum latency).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_input_debouncer;

  localparam int N_PUSH   = 10;
  localparam int N_SWITCH = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_PUSH-1:0]   raw_push;
  logic [N_SWITCH-1:0] raw_switch;

  always #5 clk = ~clk;

  input_debouncer_if #(.N_PUSH(N_PUSH), .N_SWITCH(N_SWITCH)) bus_a ();
  input_debouncer_if #(.N_PUSH(N_PUSH), .N_SWITCH(N_SWITCH)) bus_b ();

  assign bus_a.raw_push_i   = raw_push;
  assign bus_a.raw_switch_i = raw_switch;
  assign bus_b.raw_push_i   = raw_push;
  assign bus_b.raw_switch_i = raw_switch;

  input_debouncer #(
    .N_PUSH(N_PUSH), .N_SWITCH(N_SWITCH), .CNT_W(16), .STABLE_CYCLES(4)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_a)
  );

  input_debouncer #(
    .N_PUSH(N_PUSH), .N_SWITCH(N_SWITCH), .CNT_W(16), .STABLE_CYCLES(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_b)
  );

  typedef struct {
    string               tag;
    int                  idx;
    logic [N_PUSH-1:0]   push;
    logic [N_SWITCH-1:0] sw;
    logic [N_PUSH-1:0]   exp_push;
    logic [N_SWITCH-1:0] exp_sw;
    logic                exp_busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string tag, input int idx,
                     input logic [N_PUSH-1:0] p, input logic [N_SWITCH-1:0] s,
                     input logic [N_PUSH-1:0] ep, input logic [N_SWITCH-1:0] es,
                     input logic eb);
    vec_t v;
    v.tag = tag; v.idx = idx; v.push = p; v.sw = s;
    v.exp_push = ep; v.exp_sw = es; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Scoreboard consumer: each record applies to the edge following its drive.
  always @(posedge clk) begin
    vec_t r;
    #1;
    if (sb_q.size() != 0) begin
      r = sb_q.pop_front();
      check($sformatf("%s[%0d] push_o", r.tag, r.idx), 32'(bus_a.push_o), 32'(r.exp_push));
      check($sformatf("%s[%0d] switch_o", r.tag, r.idx), 32'(bus_a.switch_o), 32'(r.exp_sw));
      check($sformatf("%s[%0d] busy_o", r.tag, r.idx), 32'(bus_a.busy_o), 32'(r.exp_busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bounce_raw [12];
    int bounce_busy[12];
    bounce_raw  = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    bounce_busy = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0};

    // Vector table. Row k is driven before edge Ek; with STABLE_CYCLES=4 a
    // step first sampled at E0 shows on the output at E5, busy during E2..E4.
    for (int k = 0; k < 2; k++) add("reset_idle", k, '0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 7; k++)
      add("step_p0", k, 10'h001, 8'h00, (k >= 5) ? 10'h001 : 10'h000, 8'h00, (k >= 2 && k <= 4));
    for (int k = 0; k < 6; k++)
      add("rel_p0", k, 10'h000, 8'h00, (k >= 5) ? 10'h000 : 10'h001, 8'h00, (k >= 2 && k <= 4));
    for (int k = 0; k < 7; k++)
      add("glitch_p3", k, (k < 3) ? 10'h008 : 10'h000, 8'h00, 10'h000, 8'h00, (k >= 2 && k <= 4));
    for (int k = 0; k < 12; k++)
      add("bounce_s2", k, 10'h000, (bounce_raw[k] != 0) ? 8'h04 : 8'h00,
          10'h000, (k >= 10) ? 8'h04 : 8'h00, bounce_busy[k] != 0);
    for (int k = 0; k < 7; k++)
      add("all_up", k, 10'h3FF, 8'hFF, (k >= 5) ? 10'h3FF : 10'h000,
          (k >= 5) ? 8'hFF : 8'h04, (k >= 2 && k <= 4));
    for (int k = 0; k < 7; k++)
      add("rel_p9", k, 10'h1FF, 8'hFF, (k >= 5) ? 10'h1FF : 10'h3FF, 8'hFF, (k >= 2 && k <= 4));

    rst_n      = 1'b0;
    raw_push   = '0;
    raw_switch = '0;
    repeat (3) @(negedge clk);
    check("reset push_o", 32'(bus_a.push_o), 32'h0);
    check("reset switch_o", 32'(bus_a.switch_o), 32'h0);
    check("reset busy_o", 32'(bus_a.busy_o), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      raw_push   = vecs[i].push;
      raw_switch = vecs[i].sw;
      sb_q.push_back(vecs[i]);
    end
    for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset in the middle of a count.
    @(negedge clk);
    raw_push = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    check("midcount busy_o", 32'(bus_a.busy_o), 32'h1);
    check("midcount push_o", 32'(bus_a.push_o), 32'h1FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst push_o", 32'(bus_a.push_o), 32'h0);
    check("async rst switch_o", 32'(bus_a.switch_o), 32'h0);
    check("async rst busy_o", 32'(bus_a.busy_o), 32'h0);
    check("async rst b switch_o", 32'(bus_b.switch_o), 32'h0);
`ifdef INPUT_DEBOUNCER_EDGE_EN
    check("async rst rise_o", 32'(bus_a.rise_o), 32'h0);
    check("async rst fall_o", 32'(bus_a.fall_o), 32'h0);
`endif

    // Held input after release is re-debounced with full latency; dut_b
    // shows the minimum latency of the edge after next.
    @(negedge clk);
    rst_n      = 1'b1;
    raw_push   = 10'h001;
    raw_switch = 8'h00;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst a push_o e%0d", e), 32'(bus_a.push_o), (e >= 5) ? 32'h1 : 32'h0);
      check($sformatf("post_rst a busy_o e%0d", e), 32'(bus_a.busy_o), (e >= 2 && e <= 4) ? 32'h1 : 32'h0);
      check($sformatf("post_rst b push_o e%0d", e), 32'(bus_b.push_o), (e >= 2) ? 32'h1 : 32'h0);
    end

`ifdef INPUT_DEBOUNCER_EDGE_EN
    @(negedge clk);
    raw_push = 10'h003;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rise_o up e%0d", e), 32'(bus_a.rise_o), (e == 6) ? 32'h2 : 32'h0);
      check($sformatf("fall_o up e%0d", e), 32'(bus_a.fall_o), 32'h0);
      check($sformatf("push_o up e%0d", e), 32'(bus_a.push_o), (e >= 5) ? 32'h3 : 32'h1);
    end
    @(negedge clk);
    raw_push = 10'h001;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rise_o dn e%0d", e), 32'(bus_a.rise_o), 32'h0);
      check($sformatf("fall_o dn e%0d", e), 32'(bus_a.fall_o), (e == 6) ? 32'h2 : 32'h0);
      check($sformatf("push_o dn e%0d", e), 32'(bus_a.push_o), (e >= 5) ? 32'h1 : 32'h3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
